// File: rtl/invz_ctrl_pkg.sv
// Shared definitions for invz bank controllers.
//   state_e      : arbiter FSM state encoding (2 bits)
//   DEF_*        : default parameter values for the bus arbiter
//   clog2()      : ceiling log2, used to size OWNER and counters
package invz_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  localparam int unsigned DEF_N       = 4;
  localparam int unsigned DEF_TURN    = 2;
  localparam int unsigned DEF_MAXHOLD = 16;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(17) = 5.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned ret;
    ret = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) ret = i + 1;
    end
    return ret;
  endfunction

endpackage

// File: rtl/invz_rr_pick.sv
// Round-robin picker: first set bit of req searching upward from start, wrapping.
//   req    in  N  request vector
//   start  in  W  index searched first
//   valid  out 1  any request set
//   winner out W  selected index (0 when valid is low)
module invz_rr_pick
  import invz_ctrl_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned W = clog2(DEF_N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         valid,
  output logic [W-1:0] winner
);

  // Linear scan in rotated order; the first hit wins.
  always_comb begin
    logic [W-1:0] idx;
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = W'((32'(start) + i) % N);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/invz_bus_arbiter.sv
// Round-robin arbiter and enable sequencer for a shared tristate net of N invz cells.
// One owner at a time; a TURN-cycle all-EN-low gap separates owners.
//   CLK   in     1        clock, rising edge
//   RN    in     1        asynchronous reset, active-low
//   REQ   in     N        per-requester level request
//   GNT   out    N        one-hot or zero, current owner
//   EN    out    N        one-hot or zero, invz enable pins (always equals GNT)
//   OWNER out    clog2(N) index of current/last owner
//   BUSY  out    1        high while driving or in turnaround
//   VDD   inout  1        power, no functional use
//   VSS   inout  1        ground, no functional use
module invz_bus_arbiter
  import invz_ctrl_pkg::*;
#(
  parameter int unsigned N       = DEF_N,
  parameter int unsigned TURN    = DEF_TURN,
  parameter int unsigned MAXHOLD = DEF_MAXHOLD
) (
  input  logic                CLK,
  input  logic                RN,
  input  logic [N-1:0]        REQ,
  output logic [N-1:0]        GNT,
  output logic [N-1:0]        EN,
  output logic [clog2(N)-1:0] OWNER,
  output logic                BUSY,
  inout  wire                 VDD,
  inout  wire                 VSS
);

  localparam int unsigned OW = clog2(N);
  localparam int unsigned HW = clog2(MAXHOLD + 1);
  localparam int unsigned TW = clog2(TURN + 1);

  localparam logic [HW-1:0] HOLD_MAX = HW'(MAXHOLD);
  localparam logic [TW-1:0] TURN_LD  = TW'(TURN);

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q,   gnt_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic            busy_q,  busy_d;
  logic [HW-1:0]   hold_q,  hold_d;
  logic [TW-1:0]   turn_q,  turn_d;

  logic [OW-1:0]   start;
  logic            pick_valid;
  logic [OW-1:0]   pick_idx;
  logic [N-1:0]    owner_oh;
  logic            others_waiting;
  logic            release_bus;

  // Power pins are present for the macro netlist only.
  logic unused_pwr;
  assign unused_pwr = VDD ^ VSS;

  // Search begins just above the last owner so the ex-owner is considered last.
  assign start = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);

  assign owner_oh       = N'(1) << owner_q;
  assign others_waiting = |(REQ & ~owner_oh);
  assign release_bus    = !REQ[owner_q] || ((hold_q == HOLD_MAX) && others_waiting);

  invz_rr_pick #(
    .N (N),
    .W (OW)
  ) u_pick (
    .req    (REQ),
    .start  (start),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    hold_d  = hold_q;
    turn_d  = turn_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (pick_valid) begin
          state_d = ST_DRIVE;
          gnt_d   = N'(1) << pick_idx;
          owner_d = pick_idx;
          busy_d  = 1'b1;
          hold_d  = HW'(1);
        end
      end

      ST_DRIVE: begin
        if (release_bus) begin
          state_d = ST_TURN;
          gnt_d   = '0;
          turn_d  = TURN_LD;
          hold_d  = '0;
        end else if (hold_q == HOLD_MAX) begin
          // Nobody else is waiting: keep the net, restart the hold window.
          hold_d = HW'(1);
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end

      ST_TURN: begin
        if (turn_q == TW'(1)) begin
          turn_d = '0;
          if (pick_valid) begin
            state_d = ST_DRIVE;
            gnt_d   = N'(1) << pick_idx;
            owner_d = pick_idx;
            busy_d  = 1'b1;
            hold_d  = HW'(1);
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          turn_d = turn_q - TW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        hold_d  = '0;
        turn_d  = '0;
      end
    endcase
  end

  // State and output registers; reset forces EN low without a clock.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  assign GNT   = gnt_q;
  assign EN    = gnt_q;
  assign OWNER = owner_q;
  assign BUSY  = busy_q;

  // Structural sanity of the registered outputs.
  a_en_onehot0 : assert property (@(posedge CLK) disable iff (!RN) $onehot0(gnt_q));
  a_busy_state : assert property (@(posedge CLK) disable iff (!RN)
                                  busy_q == (state_q != ST_IDLE));

endmodule

// File: tb/tb_invz_bus_arbiter.sv
// Self-checking bench for invz_bus_arbiter (N=4, TURN=2, MAXHOLD=16).
module tb_invz_bus_arbiter;

  localparam int N       = 4;
  localparam int TURN    = 2;
  localparam int MAXHOLD = 16;
  localparam int STARVE_BOUND = (N - 1) * (MAXHOLD + TURN) + TURN;

  logic       clk;
  logic       rn;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] en;
  logic [1:0] owner;
  logic       busy;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  invz_bus_arbiter #(
    .N       (N),
    .TURN    (TURN),
    .MAXHOLD (MAXHOLD)
  ) dut (
    .CLK   (clk),
    .RN    (rn),
    .REQ   (req),
    .GNT   (gnt),
    .EN    (en),
    .OWNER (owner),
    .BUSY  (busy),
    .VDD   (vdd),
    .VSS   (vss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset held for two cycles with the given request pattern, released on a falling edge.
  task automatic do_reset(input logic [3:0] r);
    @(negedge clk);
    rn  = 1'b0;
    req = r;
    @(negedge clk);
    @(negedge clk);
    rn = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  // Ownership timeline: who holds the net, how long, and how many dead cycles remain.
  int m_owner;
  bit m_drv;
  int m_gap;
  int m_run;

  function automatic void model_reset();
    m_owner = 0;
    m_drv   = 1'b0;
    m_gap   = 0;
    m_run   = 0;
  endfunction

  function automatic int rr_next(input int r, input int from);
    for (int k = 1; k <= N; k++) begin
      if (((r >> ((from + k) % N)) & 1) != 0) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic void model_edge(input int r);
    int w;
    if (m_drv) begin
      bool_blk: begin
        bit mine, others;
        mine   = ((r >> m_owner) & 1) != 0;
        others = (r & ~(1 << m_owner)) != 0;
        if (!mine || (m_run == MAXHOLD && others)) begin
          m_drv = 1'b0;
          m_gap = TURN;
          m_run = 0;
        end else begin
          m_run = (m_run == MAXHOLD) ? 1 : m_run + 1;
        end
      end
    end else if (m_gap > 1) begin
      m_gap--;
    end else begin
      m_gap = 0;
      w = rr_next(r, m_owner);
      if (w >= 0) begin
        m_owner = w;
        m_drv   = 1'b1;
        m_run   = 1;
      end
    end
  endfunction

  function automatic int model_en();
    return m_drv ? (1 << m_owner) : 0;
  endfunction

  function automatic bit model_busy();
    return m_drv || (m_gap > 0);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] req;
    logic [3:0] en;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  vec_t vecs[24];

  int exp_owner[5];
  int zrun;
  int wait_c[N];
  int max_wait;

  initial begin
    rn  = 1'b1;
    req = 4'b0000;

    // req applied before the edge; outputs expected just after it.
    vecs[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[3]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[4]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[5]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[6]  = '{4'b0000, 4'b0000, 2'd2, 1'b1};
    vecs[7]  = '{4'b0000, 4'b0000, 2'd2, 1'b1};
    vecs[8]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};
    vecs[9]  = '{4'b1001, 4'b1000, 2'd3, 1'b1};
    vecs[10] = '{4'b1001, 4'b1000, 2'd3, 1'b1};
    vecs[11] = '{4'b0001, 4'b0000, 2'd3, 1'b1};
    vecs[12] = '{4'b0001, 4'b0000, 2'd3, 1'b1};
    vecs[13] = '{4'b0001, 4'b0001, 2'd0, 1'b1};
    vecs[14] = '{4'b0000, 4'b0000, 2'd0, 1'b1};
    vecs[15] = '{4'b0110, 4'b0000, 2'd0, 1'b1};
    vecs[16] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[17] = '{4'b0011, 4'b0010, 2'd1, 1'b1};
    vecs[18] = '{4'b0001, 4'b0000, 2'd1, 1'b1};
    vecs[19] = '{4'b0000, 4'b0000, 2'd1, 1'b1};
    vecs[20] = '{4'b0101, 4'b0100, 2'd2, 1'b1};
    vecs[21] = '{4'b0000, 4'b0000, 2'd2, 1'b1};
    vecs[22] = '{4'b0000, 4'b0000, 2'd2, 1'b1};
    vecs[23] = '{4'b0000, 4'b0000, 2'd2, 1'b0};

    // Reset with all requests pending, then first grant goes to index 1.
    @(negedge clk);
    rn  = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    chk("rst_en",    32'(en),    32'(0));
    chk("rst_gnt",   32'(gnt),   32'(0));
    chk("rst_busy",  32'(busy),  32'(0));
    chk("rst_owner", 32'(owner), 32'(0));
    rn = 1'b1;
    tick();
    chk("post_rst_gnt",   32'(gnt),   32'(4'b0010));
    chk("post_rst_owner", 32'(owner), 32'(1));
    chk("post_rst_busy",  32'(busy),  32'(1));

    // Directed table.
    do_reset(4'b0000);
    for (int i = 0; i < 24; i++) begin
      req = vecs[i].req;
      tick();
      chk($sformatf("vec%0d_en", i),    32'(en),    32'(vecs[i].en));
      chk($sformatf("vec%0d_gnt", i),   32'(gnt),   32'(vecs[i].en));
      chk($sformatf("vec%0d_owner", i), 32'(owner), 32'(vecs[i].owner));
      chk($sformatf("vec%0d_busy", i),  32'(busy),  32'(vecs[i].busy));
    end

    // All requesting: rotation 1,2,3,0,1 with MAXHOLD-long tenures and TURN-long gaps.
    exp_owner = '{1, 2, 3, 0, 1};
    do_reset(4'b1111);
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < MAXHOLD; c++) begin
        tick();
        chk($sformatf("rr_own%0d_en", k), 32'(en), 32'(1 << exp_owner[k]));
      end
      if (k < 4) begin
        for (int g = 0; g < TURN; g++) begin
          tick();
          chk($sformatf("rr_gap%0d_en", k), 32'(en), 32'(0));
          chk($sformatf("rr_gap%0d_busy", k), 32'(busy), 32'(1));
        end
      end
    end

    // Lone requester keeps the net across hold-window wraps.
    do_reset(4'b0001);
    for (int c = 0; c < 40; c++) begin
      tick();
      chk($sformatf("solo_c%0d_en", c), 32'(en), 32'(4'b0001));
    end
    req = 4'b0000;
    tick();
    chk("solo_release_en", 32'(en), 32'(0));

    // Asynchronous reset mid-drive clears EN before the next clock.
    do_reset(4'b0100);
    tick();
    tick();
    chk("async_pre_en", 32'(en), 32'(4'b0100));
    @(negedge clk);
    #1;
    rn = 1'b0;
    #1;
    chk("async_en",    32'(en),    32'(0));
    chk("async_busy",  32'(busy),  32'(0));
    chk("async_owner", 32'(owner), 32'(0));
    #1;
    rn  = 1'b1;
    req = 4'b0111;
    tick();
    chk("async_regrant_en",    32'(en),    32'(4'b0010));
    chk("async_regrant_owner", 32'(owner), 32'(1));

    // Randomized traffic against the reference model.
    do_reset(4'b0000);
    model_reset();
    zrun     = 0;
    max_wait = 0;
    for (int i = 0; i < N; i++) wait_c[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int cur, nr;
      cur = int'(req);
      nr  = 0;
      for (int i = 0; i < N; i++) begin
        bit on;
        on = ((cur >> i) & 1) != 0;
        if (!on) on = ($urandom_range(0, 9) == 0);
        else if (m_drv && m_owner == i) on = ($urandom_range(0, 19) != 0);
        if (on) nr |= (1 << i);
      end
      req = 4'(nr);
      model_edge(nr);
      tick();
      chk("rand_outputs", {23'd0, en, gnt, owner, busy},
          {23'd0, 4'(model_en()), 4'(model_en()), 2'(m_owner), model_busy()});
      if (en == 4'b0000 && busy) begin
        zrun++;
      end else begin
        if (zrun > 0) chk("rand_gap_len", 32'(zrun), 32'(TURN));
        zrun = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (((nr >> i) & 1) != 0 && ((int'(en) >> i) & 1) == 0) wait_c[i]++;
        else wait_c[i] = 0;
        if (wait_c[i] > max_wait) max_wait = wait_c[i];
      end
    end
    chk("rand_starvation_ok", 32'(max_wait <= STARVE_BOUND), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
